// File: rtl/clk_gate_pkg.sv
// Shared types and defaults for the clock-gating controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        COUNT = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } gate_state_t;

    localparam int DEF_IDLE_CYCLES = 8;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int GATED_CNT_W     = 16;

    // Saturating +1 for the gated-cycle counter.
    function automatic logic [GATED_CNT_W-1:0] sat_inc(input logic [GATED_CNT_W-1:0] v);
        return (v == '1) ? v : v + GATED_CNT_W'(1);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Control/status bundle between the clock-gating controller and its user.
interface clk_gate_ctrl_if;
    import clk_gate_pkg::*;

    logic                   activity;
    logic                   force_on;
    logic                   enable;
    logic                   gated_clk;
    logic                   ready;
    logic [GATED_CNT_W-1:0] gated_cnt;

    modport master (
        output activity,
        output force_on,
        input  enable,
        input  gated_clk,
        input  ready,
        input  gated_cnt
    );

    modport slave (
        input  activity,
        input  force_on,
        output enable,
        output gated_clk,
        output ready,
        output gated_cnt
    );

endinterface

// File: rtl/icg_cell.sv
// Glitch-free clock gate: enable is only allowed to change while clk is low.
// CLK_GATE_LATCH_EN selects a low-transparent latch; otherwise a negedge flop.
module icg_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);

`ifdef CLK_GATE_LATCH_EN
    logic en_l;

    always_latch begin
        if (!clk) en_l <= en;
    end

    assign gclk = clk & en_l;
`else
    logic en_q;

    // Capturing on the falling edge holds the enable stable for the whole high phase.
    always_ff @(negedge clk) begin
        en_q <= en;
    end

    assign gclk = clk & en_q;
`endif

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gating controller with a wake-up settle period before ready.
// Gate style chosen in icg_cell via CLK_GATE_LATCH_EN; FSM timing is build-independent.
//
// state | meaning
// RUN   | clock running, no idle seen
// COUNT | clock running, counting consecutive idle cycles
// GATED | clock stopped, counting gated cycles
// WAKE  | clock running again, waiting for it to settle before ready
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    clk_gate_ctrl_if.slave bus
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    gate_state_t            state;
    gate_state_t            state_nxt;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [IDLE_W-1:0]      idle_nxt;
    logic [WAKE_W-1:0]      wake_cnt;
    logic [WAKE_W-1:0]      wake_nxt;
    logic                   wake_req;
    logic                   enable_q;
    logic                   ready_q;
    logic [GATED_CNT_W-1:0] gated_cnt_q;
    logic                   gclk;

    assign wake_req = bus.activity | bus.force_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            idle_cnt    <= '0;
            wake_cnt    <= '0;
            enable_q    <= 1'b1;
            ready_q     <= 1'b1;
            gated_cnt_q <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
            // Outputs are registered from the next state so they move with the state itself.
            enable_q <= (state_nxt != GATED);
            ready_q  <= (state_nxt == RUN) || (state_nxt == COUNT);
            if (state == GATED) gated_cnt_q <= sat_inc(gated_cnt_q);
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        case (state)
            RUN: begin
                if (wake_req) begin
                    idle_nxt = '0;
                end else begin
                    state_nxt = COUNT;
                    idle_nxt  = IDLE_W'(1);
                end
            end
            COUNT: begin
                // Activity is tested first so it wins over the terminal idle count.
                if (wake_req) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt = GATED;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            GATED: begin
                if (wake_req) begin
                    state_nxt = WAKE;
                    wake_nxt  = '0;
                end
            end
            WAKE: begin
                // Wake always runs to completion regardless of activity.
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = RUN;
                    wake_nxt  = '0;
                end else begin
                    wake_nxt = wake_cnt + WAKE_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                idle_nxt  = '0;
                wake_nxt  = '0;
            end
        endcase
    end

    icg_cell u_icg (
        .clk  (clk),
        .en   (enable_q),
        .gclk (gclk)
    );

    assign bus.enable    = enable_q;
    assign bus.ready     = ready_q;
    assign bus.gated_cnt = gated_cnt_q;
    assign bus.gated_clk = gclk;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus random activity against a behavioural model.
module tb_clk_gate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   e;
    bit   run_chk;

    clk_gate_ctrl_if bus ();

    clk_gate_ctrl #(
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: idle streak length, gated flag, remaining wake cycles.
    bit m_gated;
    int m_streak;
    int m_wake_left;
    int m_gcnt;

    function automatic bit m_enable();
        return !m_gated;
    endfunction

    function automatic bit m_ready();
        return !m_gated && (m_wake_left == 0);
    endfunction

    task automatic model_reset();
        m_gated     = 1'b0;
        m_streak    = 0;
        m_wake_left = 0;
        m_gcnt      = 0;
    endtask

    task automatic model_step(input bit a, input bit f);
        if (m_gated) begin
            if (m_gcnt < 65535) m_gcnt++;
            if (a || f) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            if (m_wake_left == 0) m_streak = 0;
        end else begin
            if (a || f) m_streak = 0;
            else m_streak++;
            if (m_streak > IDLE) begin
                m_gated  = 1'b1;
                m_streak = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge rst) model_reset();

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        if (rst && run_chk) begin
            automatic bit exp_g = m_enable();
            model_step(bus.activity, bus.force_on);
            #1;
            chk("m_enable", {31'd0, bus.enable}, {31'd0, m_enable()});
            chk("m_ready", {31'd0, bus.ready}, {31'd0, m_ready()});
            chk("m_gated_cnt", {16'd0, bus.gated_cnt}, m_gcnt);
            chk("m_gclk_high", {31'd0, bus.gated_clk}, {31'd0, exp_g});
        end
    end

    always @(negedge clk) begin
        if (rst && run_chk) begin
            #1;
            chk("gclk_low_phase", {31'd0, bus.gated_clk}, 32'd0);
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
        e++;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        chk("rst_enable", {31'd0, bus.enable}, 32'd1);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_gated_cnt", {16'd0, bus.gated_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        e = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        run_chk      = 1'b0;
        e            = 0;
        model_reset();
        rst          = 1'b0;
        bus.activity = 1'b1;
        bus.force_on = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("por_enable", {31'd0, bus.enable}, 32'd1);
        chk("por_ready", {31'd0, bus.ready}, 32'd1);
        chk("por_gated_cnt", {16'd0, bus.gated_cnt}, 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        run_chk = 1'b1;
        e       = 0;

        // Idle gating: activity low sampled from edge 10 gates after edge 14.
        while (e < 9) next();
        bus.activity = 1'b0;
        while (e < 13) next();
        chk("idle_e13_enable", {31'd0, bus.enable}, 32'd1);
        next();
        chk("idle_e14_enable", {31'd0, bus.enable}, 32'd0);
        chk("idle_e14_ready", {31'd0, bus.ready}, 32'd0);
        next();
        next();
        chk("gclk_flat_high_phase", {31'd0, bus.gated_clk}, 32'd0);

        // Wake: activity at edge 30, ready after edge 32.
        while (e < 29) next();
        bus.activity = 1'b1;
        next();
        chk("wake_e30_enable", {31'd0, bus.enable}, 32'd1);
        chk("wake_e30_ready", {31'd0, bus.ready}, 32'd0);
        chk("wake_e30_gated_cnt", {16'd0, bus.gated_cnt}, 32'd16);
        next();
        chk("wake_e31_ready", {31'd0, bus.ready}, 32'd0);
        next();
        chk("wake_e32_ready", {31'd0, bus.ready}, 32'd1);

        // Idle abort: low for edges 33-35, high at 36.
        bus.activity = 1'b0;
        while (e < 35) begin
            next();
            chk("abort_enable", {31'd0, bus.enable}, 32'd1);
        end
        bus.activity = 1'b1;
        while (e < 40) begin
            next();
            chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        end

        // Activity exactly at terminal count wins.
        bus.activity = 1'b0;
        while (e < 44) next();
        bus.activity = 1'b1;
        next();
        chk("terminal_tie_enable", {31'd0, bus.enable}, 32'd1);
        next();
        chk("terminal_tie_enable2", {31'd0, bus.enable}, 32'd1);

        // Wake completes even when activity drops after one cycle.
        bus.activity = 1'b0;
        while (e < 55) next();
        chk("pulse_pre_enable", {31'd0, bus.enable}, 32'd0);
        bus.activity = 1'b1;
        next();
        bus.activity = 1'b0;
        while (e < 58) next();
        chk("pulse_wake_ready", {31'd0, bus.ready}, 32'd1);
        while (e < 62) next();
        chk("regate_e62_enable", {31'd0, bus.enable}, 32'd1);
        next();
        chk("regate_e63_enable", {31'd0, bus.enable}, 32'd0);
        next();

        // Reset while gated, then force_on override for 100 idle cycles.
        reset_pulse();
        bus.force_on = 1'b1;
        repeat (100) next();
        chk("force_enable", {31'd0, bus.enable}, 32'd1);
        chk("force_gated_cnt", {16'd0, bus.gated_cnt}, 32'd0);

        // Reset one cycle into WAKE.
        bus.force_on = 1'b0;
        repeat (8) next();
        bus.activity = 1'b1;
        next();
        next();
        chk("midwake_ready", {31'd0, bus.ready}, 32'd0);
        reset_pulse();
        bus.activity = 1'b0;

        // Randomised activity, override and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            bus.activity = ($urandom_range(0, 99) < 18);
            bus.force_on = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else next();
        end

        // Saturation of the gated-cycle counter.
        bus.activity = 1'b0;
        bus.force_on = 1'b0;
        repeat (70010) next();
        chk("sat_gated_cnt", {16'd0, bus.gated_cnt}, 32'h0000_FFFF);
        repeat (20) next();
        chk("sat_hold_gated_cnt", {16'd0, bus.gated_cnt}, 32'h0000_FFFF);
        chk("sat_enable", {31'd0, bus.enable}, 32'd0);

        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 8, meaning consecutive idle cycles before the clock is gated (legal range 1..255).
REQ-002 The block SHALL have parameter WAKE_CYCLES, default 2, meaning cycles of running gated clock before ready is raised (legal range 1..15).
REQ-003 clk  input  1  free-running main clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 activity  input  1  downstream has work; synchronous to clk.
REQ-006 force_on  input  1  level override; holds the clock ungated while high.
REQ-007 enable  output  1  registered clock-gating enable driven to the gated flop domain.
REQ-008 gated_clk  output  1  glitch-free gated clock derived from clk and enable.
REQ-009 ready  output  1  gated domain clock is stable and the domain may accept data.
REQ-010 gated_cnt  output  16  count of clk cycles spent in state GATED, saturating.

Function
REQ-011 The FSM SHALL have states RUN, COUNT, GATED, WAKE; enable=1 in RUN, COUNT, WAKE; enable=0 in GATED.
REQ-012 ready SHALL be 1 in RUN and COUNT only.
REQ-013 RUN: activity=0 and force_on=0 at a posedge -> COUNT with idle counter=1; otherwise stay RUN, counter=0.
REQ-014 COUNT: activity=1 or force_on=1 -> RUN, counter=0; else counter increments; counter==IDLE_CYCLES with activity=0 -> GATED.
REQ-015 Latency: activity low sampled from edge k onward SHALL drive enable low after edge k+IDLE_CYCLES.
REQ-016 Simultaneous activity=1 and terminal idle count SHALL resolve to RUN (activity wins).
REQ-017 GATED: activity=1 or force_on=1 -> WAKE, wake counter=0; no direct GATED->RUN transition.
REQ-018 WAKE: wake counter increments each cycle; at WAKE_CYCLES -> RUN; ready SHALL rise after edge m+WAKE_CYCLES when wake was entered at edge m.
REQ-019 WAKE SHALL NOT abort if activity drops; the sequence completes to RUN, then normal idle counting applies.
REQ-020 gated_cnt SHALL increment once per cycle in GATED and hold at 16'hFFFF.
REQ-021 Counter widths SHALL be $clog2(IDLE_CYCLES+1) and $clog2(WAKE_CYCLES+1) bits; no wrap-around inside legal range.
REQ-022 gated_clk SHALL never produce a runt pulse; enable changes reach gated_clk only while clk is low.

Reset
REQ-023 rst low SHALL immediately force state RUN, enable=1, ready=1, both counters=0, gated_cnt=0.
REQ-024 Reset asserted mid-GATED or mid-WAKE SHALL abandon the sequence and return to RUN with the REQ-023 values.
REQ-025 Release of rst SHALL take effect at the first posedge after deassertion; no synchronizer is included.

Configuration
REQ-026 Macro CLK_GATE_LATCH_EN defined: gated_clk = clk AND latch(enable), latch transparent while clk low.
REQ-027 Macro absent: gated_clk = clk AND a negedge-clk flop copy of enable; FSM timing of enable/ready is identical in both builds.

Structure
REQ-028 Package clk_gate_pkg SHALL hold the state enum (RUN, COUNT, GATED, WAKE), default IDLE_CYCLES/WAKE_CYCLES constants, and gated_cnt width constant.
REQ-029 The gate-cell logic SHALL be the sub-module icg_cell (ports clk, en, gclk), containing the macro selection.

Verification
REQ-030 Idle gating: IDLE_CYCLES=4, activity low from edge 10 -> enable=0 after edge 14, ready=0, gated_clk flat low.
REQ-031 Idle abort: activity low edges 10-12, high at edge 13 -> state RUN, enable never drops, counter=0.
REQ-032 Wake: in GATED, activity high at edge 30, WAKE_CYCLES=2 -> enable=1 after edge 30, ready=1 after edge 32, no gated_clk glitch.
REQ-033 Override: force_on high throughout 100 cycles of activity=0 -> enable stays 1, gated_cnt stays 0.
REQ-034 Reset mid-wake: rst low one cycle after entering WAKE -> immediate enable=1, ready=1, gated_cnt=0, state RUN.
REQ-035 Saturation: hold GATED 70000 cycles -> gated_cnt=16'hFFFF and stays there.
